// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe turn scheduler: FSM states,
// winner encodings, the eight winning line masks and small board helpers.
package tictactoe_pkg;

   localparam int CELL_COUNT = 9;

   typedef enum logic [1:0] {
      P1_TURN   = 2'd0,
      P2_TURN   = 2'd1,
      CHECK     = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   localparam logic [1:0] WINNER_NONE = 2'd0;
   localparam logic [1:0] WINNER_P1   = 2'd1;
   localparam logic [1:0] WINNER_P2   = 2'd2;
   localparam logic [1:0] WINNER_DRAW = 2'd3;

   localparam logic [CELL_COUNT-1:0] FULL_BOARD = 9'h1FF;

   // Rows, columns, then diagonals; bit i of a mask is cell i.
   localparam logic [7:0][CELL_COUNT-1:0] WIN_LINES = {
      9'h007, 9'h038, 9'h1C0,
      9'h049, 9'h092, 9'h124,
      9'h111, 9'h054
   };

   function automatic logic [3:0] lowest_free(input logic [CELL_COUNT-1:0] occ);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = CELL_COUNT - 1; i >= 0; i--)
         if (!occ[i]) idx = 4'(i);
      return idx;
   endfunction

   function automatic logic [CELL_COUNT-1:0] cell_mask(input logic [3:0] idx);
      logic [CELL_COUNT-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/line_checker.sv
// Combinational win detector: asserts win when any of the eight winning
// lines is fully covered by the given player's cell vector.
module line_checker
   import tictactoe_pkg::*;
(
   input  logic [CELL_COUNT-1:0] vec,
   output logic                  win
);

   always_comb begin
      // NOTE: defaulting win before the loop keeps every path assigned, so no latch is inferred.
      win = 1'b0;
      for (int i = 0; i < 8; i++)
         if ((vec & WIN_LINES[i]) == WIN_LINES[i]) win = 1'b1;
   end

endmodule

// File: rtl/turn_scheduler.sv
// Tic-tac-toe sequencer: edge-detects the buttons, owns the cursor and the two
// occupancy vectors, runs the per-turn timer with auto-move, and detects win/draw.
module turn_scheduler
   import tictactoe_pkg::*;
#(
   parameter int TICKS_PER_SEC = 25000000,
   parameter int TURN_SECONDS  = 15
)(
   input  logic                  clk,
   input  logic                  botonRST,
   input  logic                  botonContCasilla,
   input  logic                  botonSelect,
   output logic [3:0]            cursor,
   output logic [CELL_COUNT-1:0] cells_p1,
   output logic [CELL_COUNT-1:0] cells_p2,
   output logic                  turn,
   output logic [3:0]            seconds_left,
   output logic                  juegoTerminado,
   output logic [1:0]            winner
);

   localparam int              TW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0]   TICK_MAX  = TW'(TICKS_PER_SEC - 1);
   localparam logic [3:0]      SECS_INIT = 4'(TURN_SECONDS);

   state_t                  state;
   logic [TW-1:0]           tick_cnt;
   logic                    next_prev, next_armed, sel_prev, sel_armed;
   logic                    next_pulse, sel_pulse;
   logic [CELL_COUNT-1:0]   occupied, mover_vec, place_mask;
   logic                    sel_free, tick_wrap, expire, win, do_place;
   logic [3:0]              auto_cell, place_cell;

   // A button held through reset stays disarmed until it is seen released.
   assign next_pulse = botonContCasilla & ~next_prev & next_armed;
   assign sel_pulse  = botonSelect & ~sel_prev & sel_armed;

   assign occupied   = cells_p1 | cells_p2;
   assign sel_free   = ~occupied[cursor];
   assign tick_wrap  = (tick_cnt == TICK_MAX);
   assign expire     = tick_wrap && (seconds_left == 4'd1);
   assign auto_cell  = lowest_free(occupied);
   assign do_place   = (sel_pulse && sel_free) || expire;
   assign place_cell = (sel_pulse && sel_free) ? cursor : auto_cell;
   assign place_mask = cell_mask(place_cell);
   assign mover_vec  = turn ? cells_p2 : cells_p1;

   line_checker u_line_checker (
      .vec (mover_vec),
      .win (win)
   );

   always_ff @(posedge clk or negedge botonRST) begin
      if (!botonRST) begin
         next_prev  <= 1'b0;
         next_armed <= 1'b0;
         sel_prev   <= 1'b0;
         sel_armed  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         next_prev  <= botonContCasilla;
         next_armed <= next_armed | ~botonContCasilla;
         sel_prev   <= botonSelect;
         sel_armed  <= sel_armed | ~botonSelect;
      end
   end

   always_ff @(posedge clk or negedge botonRST) begin
      if (!botonRST) begin
         state          <= P1_TURN;
         cursor         <= 4'd0;
         cells_p1       <= '0;
         cells_p2       <= '0;
         turn           <= 1'b0;
         seconds_left   <= SECS_INIT;
         juegoTerminado <= 1'b0;
         winner         <= WINNER_NONE;
         tick_cnt       <= '0;
      end else begin
         case (state)
            P1_TURN, P2_TURN: begin
               if (do_place) begin
                  if (turn) cells_p2 <= cells_p2 | place_mask;
                  else      cells_p1 <= cells_p1 | place_mask;
                  cursor <= place_cell;
                  state  <= CHECK;
               end else begin
                  if (tick_wrap) begin
                     tick_cnt     <= '0;
                     seconds_left <= seconds_left - 4'd1;
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
                  // Select outranks next even when the select itself is ignored.
                  if (next_pulse && !sel_pulse)
                     cursor <= (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
               end
            end
            CHECK: begin
               tick_cnt <= '0;
               if (win) begin
                  winner         <= turn ? WINNER_P2 : WINNER_P1;
                  juegoTerminado <= 1'b1;
                  state          <= GAME_OVER;
               end else if (occupied == FULL_BOARD) begin
                  winner         <= WINNER_DRAW;
                  juegoTerminado <= 1'b1;
                  state          <= GAME_OVER;
               end else begin
                  turn         <= ~turn;
                  seconds_left <= SECS_INIT;
                  state        <= turn ? P1_TURN : P2_TURN;
               end
            end
            GAME_OVER: begin
               if (sel_pulse) begin
                  cells_p1       <= '0;
                  cells_p2       <= '0;
                  cursor         <= 4'd0;
                  turn           <= 1'b0;
                  winner         <= WINNER_NONE;
                  juegoTerminado <= 1'b0;
                  seconds_left   <= SECS_INIT;
                  tick_cnt       <= '0;
                  state          <= P1_TURN;
               end
            end
            default: state <= P1_TURN;
         endcase
      end
   end

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench: two schedulers (15 s and 2 s turns) share the buttons and
// are compared every cycle with a board-level model, plus directed sequences.
module tb_turn_scheduler;

   localparam int TPS  = 4;
   localparam int TS_A = 15;
   localparam int TS_B = 2;
   localparam int PLAY = 0, CHK = 1, OVER = 2;

   logic clk = 1'b0;
   logic rstb = 1'b1;
   logic nxt = 1'b0;
   logic sel = 1'b0;
   bit   check_en = 1'b0;

   logic [3:0] a_cursor, b_cursor, a_secs, b_secs;
   logic [8:0] a_p1, a_p2, b_p1, b_p2;
   logic       a_turn, b_turn, a_jt, b_jt;
   logic [1:0] a_win, b_win;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   turn_scheduler #(.TICKS_PER_SEC(TPS), .TURN_SECONDS(TS_A)) dut_a (
      .clk(clk), .botonRST(rstb), .botonContCasilla(nxt), .botonSelect(sel),
      .cursor(a_cursor), .cells_p1(a_p1), .cells_p2(a_p2), .turn(a_turn),
      .seconds_left(a_secs), .juegoTerminado(a_jt), .winner(a_win)
   );

   turn_scheduler #(.TICKS_PER_SEC(TPS), .TURN_SECONDS(TS_B)) dut_b (
      .clk(clk), .botonRST(rstb), .botonContCasilla(nxt), .botonSelect(sel),
      .cursor(b_cursor), .cells_p1(b_p1), .cells_p2(b_p2), .turn(b_turn),
      .seconds_left(b_secs), .juegoTerminado(b_jt), .winner(b_win)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: board of owners, one per DUT ----------------
   int m_owner[2][9];
   int m_cursor[2], m_mover[2], m_secs[2], m_ticks[2], m_phase[2], m_win[2];
   bit m_prev_n, m_prev_s;
   int ts_of[2] = '{TS_A, TS_B};
   int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   task automatic model_reset(input int i);
      for (int c = 0; c < 9; c++) m_owner[i][c] = 0;
      m_cursor[i] = 0;
      m_mover[i]  = 1;
      m_secs[i]   = ts_of[i];
      m_ticks[i]  = 0;
      m_phase[i]  = PLAY;
      m_win[i]    = 0;
   endtask

   task automatic model_step(input int i, input bit np, input bit sp);
      int  free_cell, n_free;
      bit  won;
      case (m_phase[i])
         PLAY: begin
            if (sp && m_owner[i][m_cursor[i]] == 0) begin
               m_owner[i][m_cursor[i]] = m_mover[i];
               m_phase[i] = CHK;
            end else if (m_ticks[i] == TPS - 1 && m_secs[i] == 1) begin
               free_cell = -1;
               for (int c = 0; c < 9; c++)
                  if (free_cell < 0 && m_owner[i][c] == 0) free_cell = c;
               if (free_cell >= 0) begin
                  m_owner[i][free_cell] = m_mover[i];
                  m_cursor[i] = free_cell;
               end
               m_phase[i] = CHK;
            end else begin
               if (m_ticks[i] == TPS - 1) begin
                  m_ticks[i] = 0;
                  m_secs[i]  = m_secs[i] - 1;
               end else begin
                  m_ticks[i] = m_ticks[i] + 1;
               end
               if (np && !sp) m_cursor[i] = (m_cursor[i] + 1) % 9;
            end
         end
         CHK: begin
            m_ticks[i] = 0;
            won = 1'b0;
            for (int l = 0; l < 8; l++)
               if (m_owner[i][lines[l][0]] == m_mover[i] && m_owner[i][lines[l][1]] == m_mover[i] &&
                   m_owner[i][lines[l][2]] == m_mover[i]) won = 1'b1;
            n_free = 0;
            for (int c = 0; c < 9; c++) if (m_owner[i][c] == 0) n_free++;
            if (won) begin
               m_win[i] = m_mover[i];
               m_phase[i] = OVER;
            end else if (n_free == 0) begin
               m_win[i] = 3;
               m_phase[i] = OVER;
            end else begin
               m_mover[i] = 3 - m_mover[i];
               m_secs[i]  = ts_of[i];
               m_phase[i] = PLAY;
            end
         end
         default: if (sp) model_reset(i);
      endcase
   endtask

   task automatic compare(input int i, input logic [3:0] cur, input logic [8:0] p1, input logic [8:0] p2,
                          input logic t, input logic [3:0] secs, input logic jt, input logic [1:0] w);
      logic [8:0] e1, e2;
      string tag;
      tag = (i == 0) ? "a" : "b";
      e1 = '0;
      e2 = '0;
      for (int c = 0; c < 9; c++) begin
         if (m_owner[i][c] == 1) e1[c] = 1'b1;
         if (m_owner[i][c] == 2) e2[c] = 1'b1;
      end
      check({tag, " cursor"}, 32'(cur), 32'(m_cursor[i]));
      check({tag, " cells_p1"}, 32'(p1), 32'(e1));
      check({tag, " cells_p2"}, 32'(p2), 32'(e2));
      check({tag, " turn"}, 32'(t), 32'(m_mover[i] - 1));
      check({tag, " seconds_left"}, 32'(secs), 32'(m_secs[i]));
      check({tag, " juegoTerminado"}, 32'(jt), 32'(m_phase[i] == OVER));
      check({tag, " winner"}, 32'(w), 32'(m_win[i]));
      check({tag, " overlap"}, 32'(p1 & p2), 32'd0);
   endtask

   always @(posedge clk) begin : model_blk
      bit np, sp;
      np = nxt && !m_prev_n;
      sp = sel && !m_prev_s;
      if (!rstb) begin
         model_reset(0);
         model_reset(1);
         m_prev_n = 1'b1;
         m_prev_s = 1'b1;
      end else begin
         model_step(0, np, sp);
         model_step(1, np, sp);
         m_prev_n = nxt;
         m_prev_s = sel;
      end
      #1;
      if (check_en) begin
         compare(0, a_cursor, a_p1, a_p2, a_turn, a_secs, a_jt, a_win);
         compare(1, b_cursor, b_p1, b_p2, b_turn, b_secs, b_jt, b_win);
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic step(input bit n, input bit s);
      nxt = n;
      sel = s;
      @(negedge clk);
   endtask

   task automatic press_next();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic press_sel();
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
   endtask

   task automatic goto(input int target);
      for (int k = 0; k < 9 && m_cursor[0] != target; k++) press_next();
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      nxt = 1'b0;
      sel = 1'b0;
      check_en = 1'b1;
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
   endtask

   typedef struct packed {
      bit         n;
      bit         s;
      logic [3:0] cur;
      logic [8:0] p1;
      logic [8:0] p2;
      bit         t;
   } vec_t;

   function automatic vec_t v(input bit n, input bit s, input logic [3:0] cur,
                              input logic [8:0] p1, input logic [8:0] p2, input bit t);
      vec_t r;
      r = '{n: n, s: s, cur: cur, p1: p1, p2: p2, t: t};
      return r;
   endfunction

   initial begin
      vec_t tbl[$];
      int   ord[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      int   k;

      tbl.push_back(v(1, 0, 4'd1, 9'h000, 9'h000, 0));
      tbl.push_back(v(1, 0, 4'd1, 9'h000, 9'h000, 0));   // held: no second pulse
      tbl.push_back(v(0, 0, 4'd1, 9'h000, 9'h000, 0));
      tbl.push_back(v(1, 0, 4'd2, 9'h000, 9'h000, 0));
      tbl.push_back(v(0, 0, 4'd2, 9'h000, 9'h000, 0));
      tbl.push_back(v(1, 0, 4'd3, 9'h000, 9'h000, 0));
      tbl.push_back(v(0, 0, 4'd3, 9'h000, 9'h000, 0));
      tbl.push_back(v(0, 1, 4'd3, 9'h008, 9'h000, 0));   // cell bit one cycle after edge
      tbl.push_back(v(0, 0, 4'd3, 9'h008, 9'h000, 1));   // turn toggles a cycle later
      tbl.push_back(v(0, 1, 4'd3, 9'h008, 9'h000, 1));   // occupied: ignored
      tbl.push_back(v(0, 0, 4'd3, 9'h008, 9'h000, 1));
      tbl.push_back(v(1, 1, 4'd3, 9'h008, 9'h000, 1));   // select beats next
      tbl.push_back(v(0, 0, 4'd3, 9'h008, 9'h000, 1));
      tbl.push_back(v(1, 0, 4'd4, 9'h008, 9'h000, 1));
      tbl.push_back(v(0, 0, 4'd4, 9'h008, 9'h000, 1));
      tbl.push_back(v(0, 1, 4'd4, 9'h008, 9'h010, 1));
      tbl.push_back(v(0, 0, 4'd4, 9'h008, 9'h010, 0));

      @(negedge clk);

      // Reset state
      do_reset();
      check("reset cursor", 32'(a_cursor), 32'd0);
      check("reset cells_p1", 32'(a_p1), 32'd0);
      check("reset cells_p2", 32'(a_p2), 32'd0);
      check("reset turn", 32'(a_turn), 32'd0);
      check("reset seconds_left", 32'(a_secs), 32'd15);
      check("reset juegoTerminado", 32'(a_jt), 32'd0);
      check("reset winner", 32'(a_win), 32'd0);

      // Table-driven opening
      foreach (tbl[i]) begin
         step(tbl[i].n, tbl[i].s);
         check($sformatf("vec%0d cursor", i), 32'(a_cursor), 32'(tbl[i].cur));
         check($sformatf("vec%0d cells_p1", i), 32'(a_p1), 32'(tbl[i].p1));
         check($sformatf("vec%0d cells_p2", i), 32'(a_p2), 32'(tbl[i].p2));
         check($sformatf("vec%0d turn", i), 32'(a_turn), 32'(tbl[i].t));
      end

      // P1 wins on the top row
      do_reset();
      goto(0); press_sel();
      goto(3); press_sel();
      goto(1); press_sel();
      goto(4); press_sel();
      goto(2);
      step(1'b0, 1'b1);
      check("win cell visible", 32'(a_p1), 32'h007);
      check("win not yet flagged", 32'(a_jt), 32'd0);
      step(1'b0, 1'b0);
      check("win winner", 32'(a_win), 32'd1);
      check("win juegoTerminado", 32'(a_jt), 32'd1);
      check("win cells_p1", 32'(a_p1), 32'h007);
      check("win cells_p2", 32'(a_p2), 32'h018);
      press_next();
      press_next();
      check("game over cursor frozen", 32'(a_cursor), 32'd2);

      // Full board without a line: draw, then restart
      do_reset();
      foreach (ord[i]) begin
         goto(ord[i]);
         press_sel();
      end
      check("draw winner", 32'(a_win), 32'd3);
      check("draw juegoTerminado", 32'(a_jt), 32'd1);
      check("draw cells_p1", 32'(a_p1), 32'h18D);
      check("draw cells_p2", 32'(a_p2), 32'h072);
      press_sel();
      check("restart cells_p1", 32'(a_p1), 32'd0);
      check("restart cells_p2", 32'(a_p2), 32'd0);
      check("restart turn", 32'(a_turn), 32'd0);
      check("restart winner", 32'(a_win), 32'd0);
      check("restart cursor", 32'(a_cursor), 32'd0);

      // Idle fresh game on the 2-second scheduler: auto-move after 8 cycles
      rstb = 1'b0;
      nxt = 1'b0;
      sel = 1'b0;
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      k = 0;
      while (k < 20 && b_p1 == 9'h000) begin
         @(negedge clk);
         k++;
      end
      check("auto-move cycles", 32'(k), 32'd8);
      check("auto-move cell", 32'(b_p1), 32'h001);
      check("auto-move cursor", 32'(b_cursor), 32'd0);
      check("auto-move seconds_left", 32'(b_secs), 32'd1);
      @(negedge clk);
      check("auto-move turn", 32'(b_turn), 32'd1);
      check("auto-move reload", 32'(b_secs), 32'd2);

      // Reset mid-turn with both buttons held across release
      do_reset();
      press_next();
      step(1'b0, 1'b0);
      nxt = 1'b1;
      sel = 1'b1;
      rstb = 1'b0;
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      repeat (3) step(1'b1, 1'b1);
      check("held reset cursor", 32'(a_cursor), 32'd0);
      check("held reset cells_p1", 32'(a_p1), 32'd0);
      check("held reset turn", 32'(a_turn), 32'd0);
      check("held reset seconds_left", 32'(a_secs), 32'd15);
      check("held reset b seconds_left", 32'(b_secs), 32'd2);
      check("held reset winner", 32'(a_win), 32'd0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check("re-press next", 32'(a_cursor), 32'd1);
      check("no select after release", 32'(a_p1), 32'd0);

      // Random play, occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 799) == 0) rstb = 1'b0;
         step($urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0);
         rstb = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
